// File: rtl/fetch_prefetch_unit_if.sv
// Bus bundle between the fetch/prefetch unit, instruction memory and decode.
// The unit uses the master modport; the memory/decode side uses the slave modport.
interface fetch_prefetch_unit_if;
    // Each channel transfers on a rising clock edge where its valid and ready are both high.
    // Valid never waits for ready, and the payload is held stable while valid is high.
    // The response channel has no ready: every rsp_valid_i cycle delivers one word, in request order.
    logic        req_valid_o;
    logic        req_ready_i;
    logic [31:0] req_addr_o;
    logic        rsp_valid_i;
    logic [31:0] rsp_data_i;
    logic        redirect_i;
    logic [31:0] redirect_addr_i;
    logic        inst_valid_o;
    logic        inst_ready_i;
    logic [31:0] inst_o;
    logic [31:0] pc_o;
    logic [31:0] pc_plus_o;

    modport master (
        output req_valid_o, req_addr_o, inst_valid_o, inst_o, pc_o, pc_plus_o,
        input  req_ready_i, rsp_valid_i, rsp_data_i, redirect_i, redirect_addr_i, inst_ready_i
    );

    modport slave (
        input  req_valid_o, req_addr_o, inst_valid_o, inst_o, pc_o, pc_plus_o,
        output req_ready_i, rsp_valid_i, rsp_data_i, redirect_i, redirect_addr_i, inst_ready_i
    );
endinterface

// File: rtl/fetch_prefetch_unit.sv
// Sequential instruction prefetcher with a DEPTH-entry buffer, redirect flush and stale-response drop.
// Optional FETCH_PERF_EN adds issued/dropped/stall performance counters.
module fetch_prefetch_unit #(
    parameter int unsigned DEPTH      = 4,
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter int unsigned CW         = $clog2(DEPTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    fetch_prefetch_unit_if.master bus
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]           perf_issued_o,
    output logic [31:0]           perf_dropped_o,
    output logic [31:0]           perf_stall_o
`endif
);
    localparam int unsigned    PW      = $clog2(DEPTH);
    localparam logic [CW:0]    L_DEPTH = (CW + 1)'(DEPTH);

    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_rsp_pc;
    logic [CW-1:0] r_occ;
    logic [CW-1:0] r_out;
    logic [CW-1:0] r_drop;
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [31:0]   r_mem_inst [DEPTH];
    logic [31:0]   r_mem_pc   [DEPTH];
    logic [31:0]   r_mem_pcp  [DEPTH];

    logic          w_redirect;
    logic [31:0]   w_redirect_pc;
    logic [CW:0]   w_credit;
    logic          w_req_valid;
    logic          w_issue;
    logic          w_inst_valid;
    logic          w_drop_rsp;
    logic          w_push;
    logic          w_pop;
    logic [CW-1:0] w_occ_nxt;
    logic [CW-1:0] w_out_nxt;
    logic [CW-1:0] w_drop_nxt;

    assign w_redirect    = bus.redirect_i;
    assign w_redirect_pc = bus.redirect_addr_i & 32'hFFFF_FFFC;

    // Buffered plus in-flight words never exceed DEPTH, so a push always finds a free slot.
    assign w_credit     = {1'b0, r_occ} + {1'b0, r_out};
    assign w_req_valid  = rst_ni && !w_redirect && (w_credit < L_DEPTH);
    assign w_issue      = w_req_valid && bus.req_ready_i;
    assign w_inst_valid = (r_occ != '0);
    assign w_drop_rsp   = bus.rsp_valid_i && (r_drop != '0);
    assign w_push       = bus.rsp_valid_i && (r_drop == '0) && !w_redirect;
    assign w_pop        = w_inst_valid && bus.inst_ready_i && !w_redirect;

    assign bus.req_valid_o  = w_req_valid;
    assign bus.req_addr_o   = r_fetch_pc;
    assign bus.inst_valid_o = w_inst_valid;
    assign bus.inst_o       = r_mem_inst[r_rd_ptr];
    assign bus.pc_o         = r_mem_pc[r_rd_ptr];
    assign bus.pc_plus_o    = r_mem_pcp[r_rd_ptr];

    always_comb begin
        w_occ_nxt  = r_occ;
        w_out_nxt  = r_out + CW'(w_issue) - CW'(bus.rsp_valid_i);
        w_drop_nxt = r_drop - CW'(w_drop_rsp);
        if (w_redirect) begin
            // Everything still in flight belongs to the old stream, minus what lands this cycle.
            w_occ_nxt  = '0;
            w_drop_nxt = r_out - CW'(bus.rsp_valid_i);
        end else begin
            w_occ_nxt  = r_occ + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_fetch_pc <= RESET_ADDR;
            r_rsp_pc   <= RESET_ADDR;
            r_occ      <= '0;
            r_out      <= '0;
            r_drop     <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_inst[i] <= '0;
                r_mem_pc[i]   <= '0;
                r_mem_pcp[i]  <= '0;
            end
        end else begin
            r_occ  <= w_occ_nxt;
            r_out  <= w_out_nxt;
            r_drop <= w_drop_nxt;
            if (w_redirect) begin
                r_fetch_pc <= w_redirect_pc;
                r_rsp_pc   <= w_redirect_pc;
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
            end else begin
                if (w_issue) begin
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                end
                if (w_push) begin
                    r_mem_inst[r_wr_ptr] <= bus.rsp_data_i;
                    r_mem_pc[r_wr_ptr]   <= r_rsp_pc;
                    r_mem_pcp[r_wr_ptr]  <= r_rsp_pc + 32'd4;
                    r_rsp_pc             <= r_rsp_pc + 32'd4;
                    r_wr_ptr             <= r_wr_ptr + PW'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PW'(1);
                end
            end
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] r_perf_issued;
    logic [31:0] r_perf_dropped;
    logic [31:0] r_perf_stall;
    logic        w_discard;

    // A response in the redirect cycle is discarded even when no drop was pending.
    assign w_discard = bus.rsp_valid_i && ((r_drop != '0) || w_redirect);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_perf_issued  <= '0;
            r_perf_dropped <= '0;
            r_perf_stall   <= '0;
        end else begin
            r_perf_issued  <= r_perf_issued + 32'(w_issue);
            r_perf_dropped <= r_perf_dropped + 32'(w_discard);
            r_perf_stall   <= r_perf_stall + 32'(!w_inst_valid && bus.inst_ready_i);
        end
    end

    assign perf_issued_o  = r_perf_issued;
    assign perf_dropped_o = r_perf_dropped;
    assign perf_stall_o   = r_perf_stall;
`endif

    always @(posedge clk_i) begin
        if (rst_ni) begin
            assert (w_credit <= L_DEPTH);
            assert (!(bus.rsp_valid_i && (r_out == '0)));
            assert (r_drop <= r_out);
        end
    end
endmodule

// File: doc/fetch_prefetch_unit.md
Name: fetch_prefetch_unit

Overview:
- Parametrised successor to the single-register fetch stage of the M10 core. Issues sequential instruction-fetch requests to a memory with arbitrary, in-order response latency.
- Buffers returned instructions in a DEPTH-entry FIFO and hands them to decode over a valid/ready handshake, with PC and PC+4 attached.
- A redirect input (taken branch/jump) flushes the FIFO and discards stale in-flight responses.
- Sits between instruction memory and the decode/pipeline-register stage.

Parameters:
- DEPTH, 4, FIFO entries and maximum in-flight requests (power of two, ≥2).
- RESET_ADDR, 32'h0000_0000, PC after reset.
- CW, $clog2(DEPTH+1), derived width of the occupancy, outstanding and drop counters.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- req_valid_o  out  1  fetch request valid.
- req_ready_i  in  1  memory accepts request.
- req_addr_o  out  32  fetch address, word-aligned.
- rsp_valid_i  in  1  memory response valid; in order, ≥1 cycle after acceptance, no backpressure.
- rsp_data_i  in  32  instruction word.
- redirect_i  in  1  taken branch/jump; flush.
- redirect_addr_i  in  32  new PC; bits [1:0] ignored and treated as 0.
- inst_valid_o  out  1  FIFO head valid.
- inst_ready_i  in  1  decode consumes head.
- inst_o  out  32  head instruction.
- pc_o  out  32  head PC.
- pc_plus_o  out  32  head PC+4.

Behaviour:
- Reset (rst_ni=0, asynchronous):
  - fetch_pc=RESET_ADDR, rsp_pc=RESET_ADDR.
  - occupancy, outstanding and drop_cnt = 0.
  - req_valid_o=0, inst_valid_o=0, inst_o/pc_o/pc_plus_o=0.
  - Memory is reset together with this block, so no stale responses arrive after reset release.
- Request issue:
  - req_valid_o = !redirect_i && (occupancy + outstanding < DEPTH). This credit rule guarantees the FIFO never overflows.
  - req_addr_o = fetch_pc.
  - On handshake (req_valid_o & req_ready_i): fetch_pc += 4, outstanding += 1.
  - Address wraps modulo 2^32.
- Response:
  - Every rsp_valid_i decrements outstanding.
  - If drop_cnt>0: the response is discarded and drop_cnt decrements.
  - Otherwise push {rsp_data_i, rsp_pc} and rsp_pc += 4.
  - A pushed entry is visible on inst_valid_o the next cycle (1-cycle latency, no bypass).
- Output:
  - inst_valid_o = occupancy != 0.
  - Head fields come from registered FIFO storage; pc_plus_o = pc_o + 4.
  - Pop on inst_valid_o & inst_ready_i.
  - Push and pop in the same cycle leave occupancy unchanged.
- Redirect (redirect_i=1 at a clock edge):
  - FIFO cleared (occupancy=0); any pop or push that cycle is ignored.
  - fetch_pc and rsp_pc = {redirect_addr_i[31:2], 2'b00}.
  - drop_cnt = outstanding − rsp_valid_i, so a response arriving in the redirect cycle is dropped too.
  - No request is issued in the redirect cycle.
  - First new request appears the following cycle.
  - A redirect while drop_cnt>0 recomputes drop_cnt by the same rule (back-to-back redirects).
- inst_valid_o may be high during the redirect cycle; the consumer ignores it, since the upstream redirect owner flushes decode.
- Counters saturate by construction; reaching DEPTH is legal, exceeding it is an assertion failure.

Optional Feature:
- FETCH_PERF_EN: adds outputs perf_issued_o[31:0] (accepted requests), perf_dropped_o[31:0] (discarded responses) and perf_stall_o[31:0] (cycles with inst_valid_o=0 and inst_ready_i=1).
  - Counters reset to 0, wrap at 2^32, and are unaffected by redirect.
- Without the macro these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Reset then idle (DEPTH=4, inst_ready_i=0, memory latency 1, req_ready_i=1): exactly 4 requests at 0x0,0x4,0x8,0xC. Then req_valid_o=0; inst_valid_o=1, pc_o=0x0, pc_plus_o=0x4.
- Streaming (inst_ready_i=1, latency 3): consumer sees consecutive PCs 0x0,0x4,0x8,… with no gaps after the pipeline fills. Outstanding never exceeds 4.
- Redirect with 3 in flight (latency 5), redirect_addr_i=0x0000_0103: next request addr 0x100. The 3 stale responses are dropped; first output is pc_o=0x100 with the data returned for the 0x100 request.
- Redirect coincident with rsp_valid_i and inst_ready_i: that response is not enqueued, occupancy=0 next cycle, drop_cnt = outstanding−1.
- Address wrap, redirect to 0xFFFF_FFF8: requests 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000. The entry with pc_o=0xFFFF_FFFC has pc_plus_o=0x0.
- Async reset asserted mid-stream, no clock edge: all outputs 0 immediately. After release, first req_addr_o=RESET_ADDR.
